dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter: fixed core priority, starvation counter for the external port,
// registered read responses. Optional exclusive lock via DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [CNT_W-1:0]  wait_cnt_nxt_s;
  logic              core_gnt_s;
  logic              ext_gnt_s;
  logic              core_rvalid_r;
  logic              ext_rvalid_r;
  logic [DATA_W-1:0] core_rdata_r;
  logic [DATA_W-1:0] ext_rdata_r;

  // Grant selection; grants are suppressed while reset is held.
  always_comb begin
    core_gnt_s = 1'b0;
    ext_gnt_s  = 1'b0;
    if (rst) begin
      core_gnt_s = 1'b0;
      ext_gnt_s  = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      ext_gnt_s = ext_req;
    end else if (ext_req && (!core_req || (wait_cnt_r == WAIT_MAX))) begin
      ext_gnt_s = 1'b1;
    end else begin
      core_gnt_s = core_req;
    end
  end

  // Next state and starvation counter (counter frozen while locked).
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_NORMAL: begin
        if (ext_gnt_s) begin
          wait_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (ext_req && (wait_cnt_r != WAIT_MAX)) begin
          wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
        end else begin
          wait_cnt_nxt_s = wait_cnt_r;
        end
`ifdef DMEM_ARB_LOCK_EN
        if (ext_gnt_s && ext_lock) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_NORMAL;
        end
`else
        state_nxt_s = ST_NORMAL;
`endif
      end
      ST_LOCKED: begin
`ifdef DMEM_ARB_LOCK_EN
        if (!ext_lock) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
`else
        state_nxt_s = ST_NORMAL;
`endif
      end
      default: begin
        state_nxt_s    = ST_NORMAL;
        wait_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // DMEM mux: the granted port drives memory; idle defaults to core values with no write.
  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (ext_gnt_s) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
    mem_we = (core_gnt_s & core_we) | (ext_gnt_s & ext_we);
  end

  // State, counter and read-response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_NORMAL;
      wait_cnt_r    <= {CNT_W{1'b0}};
      core_rvalid_r <= 1'b0;
      ext_rvalid_r  <= 1'b0;
      core_rdata_r  <= {DATA_W{1'b0}};
      ext_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      core_rvalid_r <= core_gnt_s & ~core_we;
      ext_rvalid_r  <= ext_gnt_s & ~ext_we;
      if (core_gnt_s && !core_we) begin
        core_rdata_r <= mem_rdata;
      end
      if (ext_gnt_s && !ext_we) begin
        ext_rdata_r <= mem_rdata;
      end
    end
  end

  assign core_gnt    = core_gnt_s;
  assign ext_gnt     = ext_gnt_s;
  assign core_stall  = core_req & ~core_gnt_s;
  assign core_rvalid = core_rvalid_r;
  assign ext_rvalid  = ext_rvalid_r;
  assign core_rdata  = core_rdata_r;
  assign ext_rdata   = ext_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-level reference model and
// directed scenarios; lock scenario is built only with DMEM_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int MW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, core_req, core_we, ext_req, ext_we, ext_lock;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic        core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid, mem_we;
  logic [31:0] core_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;

  localparam logic [31:0] INIT [16] = '{
    32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
    32'hDEADBEEF, 32'h55555555, 32'h66666666, 32'h77777777,
    32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
    32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};

  logic [31:0] dmem [16] = INIT;
  always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr[5:2]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .ext_lock(ext_lock),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  int n_vec = 0, n_fail = 0;
  bit check_en = 1'b0;

  // Reference model: how long ext has waited, lock ownership, memory image, pending responses.
  int          denied;
  bit          m_locked, m_core_rv, m_ext_rv, e_core, e_ext;
  logic [31:0] m_core_rd, m_ext_rd;
  logic [31:0] ref_mem [16];

  // Samples of DUT outputs taken mid-cycle by the driver.
  logic        s_core_gnt, s_ext_gnt, s_core_stall, s_core_rv, s_ext_rv;
  logic [31:0] s_core_rd, s_ext_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void compute_exp();
    if (rst) begin
      e_core = 1'b0; e_ext = 1'b0; denied = 0; m_locked = 1'b0;
      m_core_rv = 1'b0; m_ext_rv = 1'b0; m_core_rd = 32'h0; m_ext_rd = 32'h0;
    end else if (m_locked) begin
      e_ext = ext_req; e_core = 1'b0;
    end else begin
      e_ext  = ext_req && (!core_req || denied >= MW);
      e_core = core_req && !e_ext;
    end
  endfunction

  function automatic void advance();
    if (!rst) begin
      m_core_rv = e_core && !core_we;
      m_ext_rv  = e_ext && !ext_we;
      if (m_core_rv) m_core_rd = ref_mem[core_addr[5:2]];
      if (m_ext_rv)  m_ext_rd  = ref_mem[ext_addr[5:2]];
      if (e_core && core_we) ref_mem[core_addr[5:2]] = core_wdata;
      if (e_ext && ext_we)   ref_mem[ext_addr[5:2]]  = ext_wdata;
      if (m_locked) begin
        if (!ext_lock) m_locked = 1'b0;
      end else begin
        if (e_ext) denied = 0;
        else if (ext_req && denied < MW) denied++;
        if (e_ext && ext_lock) m_locked = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    compute_exp();
    @(negedge clk);
    s_core_gnt = core_gnt; s_ext_gnt = ext_gnt; s_core_stall = core_stall;
    s_core_rv = core_rvalid; s_ext_rv = ext_rvalid; s_core_rd = core_rdata; s_ext_rd = ext_rdata;
    @(posedge clk);
    advance();
    #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("core_gnt",    32'(core_gnt),    32'(e_core));
      chk("ext_gnt",     32'(ext_gnt),     32'(e_ext));
      chk("core_stall",  32'(core_stall),  32'(core_req && !e_core));
      chk("mem_we",      32'(mem_we),      32'((e_core && core_we) || (e_ext && ext_we)));
      chk("mem_addr",    mem_addr,         e_ext ? ext_addr : core_addr);
      chk("mem_wdata",   mem_wdata,        e_ext ? ext_wdata : core_wdata);
      chk("core_rvalid", 32'(core_rvalid), 32'(m_core_rv));
      chk("ext_rvalid",  32'(ext_rvalid),  32'(m_ext_rv));
      chk("core_rdata",  core_rdata,       m_core_rd);
      chk("ext_rdata",   ext_rdata,        m_ext_rd);
    end
  end

  int first;
  int pc;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = INIT[i];
    rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h4; ext_wdata = 32'h0; ext_lock = 1'b0;
    denied = 0; m_locked = 1'b0;
    check_en = 1'b1;
    tick();
    chk("reset_gnt_gated", 32'({s_core_gnt, s_ext_gnt}), 32'h0);
    chk("reset_rvalid",    32'({s_core_rv, s_ext_rv}), 32'h0);
    tick();
    rst = 1'b0; ext_req = 1'b0;

    // Core load then store.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    tick();
    chk("core_load_gnt", 32'(s_core_gnt), 32'h1);
    core_we = 1'b1; core_addr = 32'h14; core_wdata = 32'h12345678;
    tick();
    chk("core_load_rvalid", 32'(s_core_rv), 32'h1);
    chk("core_load_rdata",  s_core_rd, 32'hDEADBEEF);
    core_req = 1'b0;
    tick();
    chk("store_no_rvalid", 32'(s_core_rv), 32'h0);
    chk("store_dmem",      dmem[5], 32'h12345678);

    // Ext alone reads back a value written by the core.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'hCAFEF00D;
    tick();
    core_req = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
    tick();
    chk("ext_alone_gnt", 32'(s_ext_gnt), 32'h1);
    chk("ext_alone_core_rv", 32'(s_core_rv), 32'h0);
    ext_req = 1'b0;
    tick();
    chk("ext_alone_rvalid", 32'(s_ext_rv), 32'h1);
    chk("ext_alone_rdata",  s_ext_rd, 32'hCAFEF00D);
    chk("ext_alone_core_rv2", 32'(s_core_rv), 32'h0);

    // Starvation: both requesting, ext wins on cycle MAX_WAIT+1.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h3C; ext_wdata = 32'h0BADF00D;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (s_ext_gnt) begin
        first = c;
        break;
      end
    end
    chk("starve_first_ext_gnt", 32'(first), 32'd9);
    chk("starve_stall", 32'(s_core_stall), 32'h1);
    ext_we = 1'b0; ext_addr = 32'h8;
    tick();
    chk("starve_cnt_cleared", 32'(s_core_gnt), 32'h1);
    ext_req = 1'b0;
    tick();

    // Reset in the cycle after an accepted load.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    tick();
    rst = 1'b1; core_req = 1'b0;
    tick();
    chk("rst_rvalid", 32'(s_core_rv), 32'h0);
    chk("rst_rdata",  s_core_rd, 32'h0);
    core_req = 1'b1;
    tick();
    chk("rst_gnt", 32'(s_core_gnt), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(s_core_gnt), 32'h1);
    core_req = 1'b0;
    tick();

`ifdef DMEM_ARB_LOCK_EN
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h4; ext_lock = 1'b1;
    tick();
    chk("lock_first_ext_gnt", 32'(s_ext_gnt), 32'h1);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_core_blocked", 32'(s_core_gnt), 32'h0);
    end
    ext_lock = 1'b0; ext_req = 1'b0;
    tick();
    chk("unlock_edge_core_blocked", 32'(s_core_gnt), 32'h0);
    tick();
    chk("unlock_core_gnt", 32'(s_core_gnt), 32'h1);
    core_req = 1'b0;
    tick();
`endif

    // Randomized traffic; requesters hold until granted, occasional resets.
    for (int cyc = 0; cyc < 700; cyc++) begin
      pc = (cyc < 350) ? 60 : 95;
      rst = ($urandom_range(0, 199) == 0);
      if (!core_req || s_core_gnt) begin
        core_req = ($urandom_range(0, 99) < pc);
        core_we = 1'($urandom_range(0, 1));
        core_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        core_wdata = $urandom;
      end
      if (!ext_req || s_ext_gnt) begin
        ext_req = ($urandom_range(0, 99) < 45);
        ext_we = 1'($urandom_range(0, 1));
        ext_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        ext_wdata = $urandom;
      end
      tick();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
